// File: rtl/uart_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader_pkg
// Brief    : Shared state encodings and UART/boot frame constants.
//            Optional CSUM state is present only with BOOT_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
package uart_boot_loader_pkg;

    localparam logic [7:0] c_boot_sync      = 8'hA5;
    localparam int         c_uart_data_bits = 8;
    localparam int         c_word_bytes     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
`ifdef BOOT_LOADER_CHECKSUM_EN
        ST_CSUM  = 3'd5,
`endif
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader_if
// Brief    : RAM write port driven by the boot loader, plus the port-select.
// Revision : 1.0
// ============================================================================
interface uart_boot_loader_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              wr;
    logic              busy;

    modport master (output addr, output data, output wr, output busy);
    modport slave  (input  addr, input  data, input  wr, input  busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling timer,
//            LSB-first shift register; one-cycle valid / frame-error pulses.
// Revision : 1.0
// ============================================================================
module uart_rx_byte
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int                 c_cnt_w        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last     = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last    = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
    localparam logic [2:0]         c_bit_idx_last = 3'(c_uart_data_bits - 1);
    localparam logic [2:0]         c_bit_idx_one  = 3'd1;

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               r_meta;
    logic               r_sync;
    logic               r_sync_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_valid;
    logic               r_frame_err;

    // Line idles high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= i_rx;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick       = (r_state == RX_START) ? (r_cnt == c_half_last) : (r_cnt == c_bit_last);
        case (r_state)
            RX_IDLE:  if (r_sync_d && !r_sync) w_state_next = RX_START;
            RX_START: if (w_tick) w_state_next = r_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && (r_bit_idx == c_bit_idx_last)) w_state_next = RX_STOP;
            RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
            default:  w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if ((r_state == RX_IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            case (r_state)
                RX_START: if (w_tick) r_bit_idx <= '0;
                RX_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {r_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + c_bit_idx_one;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_valid     <= r_sync;
                        r_frame_err <= !r_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Brief    : Power-up loader: parses A5|LEN|words[|CSUM] from UART into RAM and
//            holds the core in reset until the image is accepted.
//            Optional checksum byte enabled by BOOT_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 13,
    parameter int DEPTH        = 8192
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_rx,
    uart_boot_loader_if.master ram,
    output logic               o_core_reset,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [15:0]     c_depth    = 16'(DEPTH);
    localparam logic [ADDR_W:0] c_addr_one = (ADDR_W + 1)'(1);
    localparam logic [1:0]      c_last_b   = 2'(c_word_bytes - 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_t     c_st_final = ST_CSUM;
`else
    localparam boot_state_t     c_st_final = ST_DONE;
`endif

    logic [7:0]      w_rx_byte;
    logic            w_rx_valid;
    logic            w_rx_frame_err;
    boot_state_t     r_state;
    boot_state_t     w_state_next;
    logic [7:0]      r_len_lo;
    logic [15:0]     w_len;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_addr;
    logic [ADDR_W:0] w_addr_inc;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (i_rx),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_frame_err)
    );

    always_comb begin
        w_state_next = r_state;
        w_len        = {w_rx_byte, r_len_lo};
        w_addr_inc   = r_addr + c_addr_one;
        // A framing error anywhere in the live frame kills the load.
        if (w_rx_frame_err && (r_state != ST_DONE) && (r_state != ST_ERR)) begin
            w_state_next = ST_ERR;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rx_valid && (w_rx_byte == c_boot_sync)) w_state_next = ST_LEN0;
                ST_LEN0: if (w_rx_valid) w_state_next = ST_LEN1;
                ST_LEN1: begin
                    if (w_rx_valid) begin
                        if (w_len > c_depth)       w_state_next = ST_ERR;
                        else if (w_len == 16'd0)   w_state_next = c_st_final;
                        else                       w_state_next = ST_DATA;
                    end
                end
                ST_DATA:  if (w_rx_valid && (r_byte_cnt == c_last_b)) w_state_next = ST_WRITE;
                ST_WRITE: w_state_next = (w_addr_inc == r_len) ? c_st_final : ST_DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
                ST_CSUM:  if (w_rx_valid) w_state_next = (w_rx_byte == r_csum) ? ST_DONE : ST_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_LEN0: if (w_rx_valid) r_len_lo <= w_rx_byte;
                ST_LEN1: begin
                    if (w_rx_valid) begin
                        r_len      <= w_len[ADDR_W:0];
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    // Little-endian: first byte ends up in bits [7:0] after four shifts.
                    if (w_rx_valid && !w_rx_frame_err) begin
                        r_word     <= {w_rx_byte, r_word[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ w_rx_byte;
`endif
                    end
                end
                ST_WRITE: r_addr <= w_addr_inc;
                default: ;
            endcase
        end
    end

    assign ram.addr     = r_addr[ADDR_W-1:0];
    assign ram.data     = r_word;
    assign ram.wr       = (r_state == ST_WRITE);
    assign ram.busy     = (r_state != ST_DONE);
    assign o_core_reset = (r_state != ST_DONE);
    assign o_done       = (r_state == ST_DONE);
    assign o_err        = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Brief    : Directed self-checking bench for uart_boot_loader (CPB=4, 16 words).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_boot_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;
    localparam int DP  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic core_reset;
    logic done;
    logic err;

    uart_boot_loader_if #(.ADDR_W(AW)) ram_if ();

    uart_boot_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .DEPTH        (DP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (rx),
        .ram          (ram_if),
        .o_core_reset (core_reset),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;
    int wr_count = 0;
    int overlap  = 0;
    int rx_count = 0;
    logic [AW-1:0] log_addr [0:63];
    logic [31:0]   log_data [0:63];
    logic [7:0]    txq [$];

    always @(negedge clk) begin
        if (ram_if.wr) begin
            log_addr[wr_count % 64] = ram_if.addr;
            log_data[wr_count % 64] = ram_if.data;
            wr_count = wr_count + 1;
        end
        if (ram_if.wr && done) overlap = overlap + 1;
        if (dut.u_rx.o_valid) rx_count = rx_count + 1;
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_q();
        foreach (txq[i]) send_byte(txq[i], 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Two-word image; checksum (when enabled) is supplied by the caller.
    task automatic load_frame1(input logic [7:0] csum);
        txq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_LOADER_CHECKSUM_EN
        txq.push_back(csum);
`else
        if (csum == 8'hFF) txq.push_back(8'hFF);
`endif
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (ram_if.addr !== 4'h0) begin failed++; $display("FAIL reset_addr: got %h want 0", ram_if.addr); end
        compared++; if (ram_if.data !== 32'h0) begin failed++; $display("FAIL reset_data: got %h want 0", ram_if.data); end
        compared++; if (ram_if.wr !== 1'b0) begin failed++; $display("FAIL reset_wr: got %b want 0", ram_if.wr); end
        compared++; if (ram_if.busy !== 1'b1) begin failed++; $display("FAIL reset_busy: got %b want 1", ram_if.busy); end
        compared++; if (core_reset !== 1'b1) begin failed++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
        compared++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", done); end
        compared++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_two_words();
        int base;
        do_reset();
        base = wr_count;
        // 78^56^34^12^EF^BE^AD^DE = 0x2A
        load_frame1(8'h2A);
        send_q();
        compared++; if (wr_count - base !== 2) begin failed++; $display("FAIL two_words_count: got %0d want 2", wr_count - base); end
        compared++; if (log_addr[base % 64] !== 4'h0) begin failed++; $display("FAIL two_words_addr0: got %h want 0", log_addr[base % 64]); end
        compared++; if (log_data[base % 64] !== 32'h12345678) begin failed++; $display("FAIL two_words_data0: got %h want 12345678", log_data[base % 64]); end
        compared++; if (log_addr[(base + 1) % 64] !== 4'h1) begin failed++; $display("FAIL two_words_addr1: got %h want 1", log_addr[(base + 1) % 64]); end
        compared++; if (log_data[(base + 1) % 64] !== 32'hDEADBEEF) begin failed++; $display("FAIL two_words_data1: got %h want deadbeef", log_data[(base + 1) % 64]); end
        compared++; if (done !== 1'b1) begin failed++; $display("FAIL two_words_done: got %b want 1", done); end
        compared++; if (core_reset !== 1'b0) begin failed++; $display("FAIL two_words_core_reset: got %b want 0", core_reset); end
        compared++; if (ram_if.busy !== 1'b0) begin failed++; $display("FAIL two_words_busy: got %b want 0", ram_if.busy); end
        compared++; if (err !== 1'b0) begin failed++; $display("FAIL two_words_err: got %b want 0", err); end
        compared++; if (overlap !== 0) begin failed++; $display("FAIL wr_done_overlap: got %0d want 0", overlap); end
        // Bytes after DONE are ignored.
        base = wr_count;
        txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_q();
        compared++; if (wr_count - base !== 0) begin failed++; $display("FAIL after_done_writes: got %0d want 0", wr_count - base); end
        compared++; if (done !== 1'b1) begin failed++; $display("FAIL after_done_sticky: got %b want 1", done); end
    endtask

    task automatic test_junk();
        int base;
        do_reset();
        base = wr_count;
        txq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
        txq.push_back(8'h01);
`endif
        send_q();
        compared++; if (wr_count - base !== 1) begin failed++; $display("FAIL junk_count: got %0d want 1", wr_count - base); end
        compared++; if (log_addr[base % 64] !== 4'h0) begin failed++; $display("FAIL junk_addr: got %h want 0", log_addr[base % 64]); end
        compared++; if (log_data[base % 64] !== 32'h00000001) begin failed++; $display("FAIL junk_data: got %h want 00000001", log_data[base % 64]); end
        compared++; if (done !== 1'b1) begin failed++; $display("FAIL junk_done: got %b want 1", done); end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        int base;
        do_reset();
        base = wr_count;
        load_frame1(8'h00);
        send_q();
        compared++; if (wr_count - base !== 2) begin failed++; $display("FAIL bad_csum_count: got %0d want 2", wr_count - base); end
        compared++; if (err !== 1'b1) begin failed++; $display("FAIL bad_csum_err: got %b want 1", err); end
        compared++; if (done !== 1'b0) begin failed++; $display("FAIL bad_csum_done: got %b want 0", done); end
        compared++; if (core_reset !== 1'b1) begin failed++; $display("FAIL bad_csum_core_reset: got %b want 1", core_reset); end
    endtask
`endif

    task automatic test_len_overflow();
        int base;
        do_reset();
        base = wr_count;
        txq = '{8'hA5, 8'h11, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_q();
        compared++; if (wr_count - base !== 0) begin failed++; $display("FAIL len_ovf_writes: got %0d want 0", wr_count - base); end
        compared++; if (err !== 1'b1) begin failed++; $display("FAIL len_ovf_err: got %b want 1", err); end
        compared++; if (ram_if.busy !== 1'b1) begin failed++; $display("FAIL len_ovf_busy: got %b want 1", ram_if.busy); end
        compared++; if (core_reset !== 1'b1) begin failed++; $display("FAIL len_ovf_core_reset: got %b want 1", core_reset); end
    endtask

    task automatic test_max_len();
        int base;
        do_reset();
        base = wr_count;
        txq = '{8'hA5, 8'h10, 8'h00};
        for (int k = 0; k < DP; k++) begin
            txq.push_back(8'(k)); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'hC0);
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        txq.push_back(8'h00);
`endif
        send_q();
        compared++; if (wr_count - base !== DP) begin failed++; $display("FAIL max_len_count: got %0d want %0d", wr_count - base, DP); end
        compared++; if (log_addr[(base + DP - 1) % 64] !== 4'hF) begin failed++; $display("FAIL max_len_last_addr: got %h want f", log_addr[(base + DP - 1) % 64]); end
        compared++; if (log_data[(base + DP - 1) % 64] !== 32'hC000000F) begin failed++; $display("FAIL max_len_last_data: got %h want c000000f", log_data[(base + DP - 1) % 64]); end
        compared++; if (done !== 1'b1) begin failed++; $display("FAIL max_len_done: got %b want 1", done); end
    endtask

    task automatic test_frame_err();
        int rx_base;
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        compared++; if (err !== 1'b1) begin failed++; $display("FAIL frame_err_err: got %b want 1", err); end
        compared++; if (done !== 1'b0) begin failed++; $display("FAIL frame_err_done: got %b want 0", done); end
        do_reset();
        rx_base = rx_count;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        compared++; if (rx_count - rx_base !== 0) begin failed++; $display("FAIL glitch_bytes: got %0d want 0", rx_count - rx_base); end
        compared++; if (err !== 1'b0) begin failed++; $display("FAIL glitch_err: got %b want 0", err); end
        send_byte(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        compared++; if (rx_count - rx_base !== 1) begin failed++; $display("FAIL post_glitch_bytes: got %0d want 1", rx_count - rx_base); end
        compared++; if (dut.u_rx.o_byte !== 8'h3C) begin failed++; $display("FAIL post_glitch_value: got %h want 3c", dut.u_rx.o_byte); end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = wr_count;
        txq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_q();
        compared++; if (wr_count - base !== 1) begin failed++; $display("FAIL mid_first_write: got %0d want 1", wr_count - base); end
        reset = 1'b1;
        @(negedge clk);
        compared++; if (ram_if.addr !== 4'h0) begin failed++; $display("FAIL mid_reset_addr: got %h want 0", ram_if.addr); end
        compared++; if (ram_if.data !== 32'h0) begin failed++; $display("FAIL mid_reset_data: got %h want 0", ram_if.data); end
        compared++; if (ram_if.busy !== 1'b1) begin failed++; $display("FAIL mid_reset_busy: got %b want 1", ram_if.busy); end
        compared++; if (core_reset !== 1'b1) begin failed++; $display("FAIL mid_reset_core_reset: got %b want 1", core_reset); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        base = wr_count;
        load_frame1(8'h2A);
        send_q();
        compared++; if (wr_count - base !== 2) begin failed++; $display("FAIL replay_count: got %0d want 2", wr_count - base); end
        compared++; if (log_data[base % 64] !== 32'h12345678) begin failed++; $display("FAIL replay_data0: got %h want 12345678", log_data[base % 64]); end
        compared++; if (log_data[(base + 1) % 64] !== 32'hDEADBEEF) begin failed++; $display("FAIL replay_data1: got %h want deadbeef", log_data[(base + 1) % 64]); end
        compared++; if (log_addr[(base + 1) % 64] !== 4'h1) begin failed++; $display("FAIL replay_addr1: got %h want 1", log_addr[(base + 1) % 64]); end
        compared++; if (done !== 1'b1) begin failed++; $display("FAIL replay_done: got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_junk();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_len_overflow();
        test_max_len();
        test_frame_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
